turbo_recovery_ctrl: RTL and testbench

- Frame-rate controller that sequences the road speed datapath.
- Owns turbo charges and decides when the speed unit may enter turbo mode, for how long, and when it must cool down.
- On a road collision, masks the gas input for a fixed recovery window.
- Sits between the player inputs/collision logic and the road speed unit. Drives that unit's turbo input and gates its gas input.

---
 rtl/turbo_recovery_ctrl.sv | 130 +++++++++++++
 tb/tb_turbo_recovery_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_recovery_ctrl.sv
// Frame-rate turbo/recovery sequencer for the road speed unit: owns turbo charges,
// times turbo and cooldown, and masks gas for a fixed window after a collision.
module turbo_recovery_ctrl #(
   parameter int TURBO_FRAMES    = 90,
   parameter int COOLDOWN_FRAMES = 60,
   parameter int RECOVER_FRAMES  = 30,
   parameter int MAX_CHARGES     = 3,
   parameter int MIN_TURBO_SPEED = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       turbo_pickup,
   input  logic       turbo_key,
   input  logic       gas_key,
   input  logic       road_collision,
   input  logic [3:0] road_speed,
   output logic       turbo,
   output logic       gas_out,
   output logic       recovering,
   output logic [1:0] charges,
   output logic [7:0] frames_left
);

   localparam logic [7:0] TURBO_LD   = 8'(TURBO_FRAMES);
   localparam logic [7:0] COOL_LD    = 8'(COOLDOWN_FRAMES);
   localparam logic [7:0] RECOVER_LD = 8'(RECOVER_FRAMES);
   localparam logic [1:0] MAX_CH     = 2'(MAX_CHARGES);
   localparam logic [3:0] MIN_SPEED  = 4'(MIN_TURBO_SPEED);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TURBO,
      S_COOLDOWN,
      S_RECOVER
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] charges_q, charges_d;
   logic       key_prev_q, key_prev_d;
   logic       turbo_q, recovering_q;
   logic       key_edge, activate;

   assign key_edge = startOfFrame & turbo_key & ~key_prev_q;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      charges_d  = charges_q;
      key_prev_d = startOfFrame ? turbo_key : key_prev_q;
      activate   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (key_edge && (charges_q != 2'd0) && (road_speed >= MIN_SPEED)) begin
               activate = 1'b1;
               state_d  = S_TURBO;
               cnt_d    = TURBO_LD;
            end
         end
         S_TURBO: begin
            if (startOfFrame) begin
               if (cnt_q == 8'd1) begin
                  state_d = S_COOLDOWN;
                  cnt_d   = COOL_LD;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_COOLDOWN, S_RECOVER: begin
            if (startOfFrame) begin
               if (cnt_q == 8'd1) begin
                  state_d = S_IDLE;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // A collision overrides any timed exit or activation, and consumes no charge.
      if (road_collision) begin
         state_d  = S_RECOVER;
         cnt_d    = RECOVER_LD;
         activate = 1'b0;
      end

      if (turbo_pickup && activate) begin
         charges_d = charges_q;
      end else if (turbo_pickup && (charges_q != MAX_CH)) begin
         charges_d = charges_q + 2'd1;
      end else if (activate) begin
         charges_d = charges_q - 2'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         charges_q    <= 2'd0;
         key_prev_q   <= 1'b0;
         turbo_q      <= 1'b0;
         recovering_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         charges_q    <= charges_d;
         key_prev_q   <= key_prev_d;
         turbo_q      <= (state_d == S_TURBO);
         recovering_q <= (state_d == S_RECOVER);
      end
   end

   assign turbo       = turbo_q;
   assign recovering  = recovering_q;
   assign charges     = charges_q;
   assign frames_left = cnt_q;
   assign gas_out     = gas_key & ~recovering_q;

endmodule

// File: tb/tb_turbo_recovery_ctrl.sv
// Directed and randomized bench for turbo_recovery_ctrl against a frame-level reference model.
module tb_turbo_recovery_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       turbo_pickup = 1'b0;
   logic       turbo_key = 1'b0;
   logic       gas_key = 1'b0;
   logic       road_collision = 1'b0;
   logic [3:0] road_speed = 4'd0;
   logic       turbo;
   logic       gas_out;
   logic       recovering;
   logic [1:0] charges;
   logic [7:0] frames_left;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: a mode, its remaining frame count, stored charges, last sampled key.
   localparam int M_IDLE = 0, M_TURBO = 1, M_COOL = 2, M_REC = 3;
   int m_mode = M_IDLE;
   int m_left = 0;
   int m_ch   = 0;
   bit m_prev = 1'b0;

   turbo_recovery_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .turbo_pickup   (turbo_pickup),
      .turbo_key      (turbo_key),
      .gas_key        (gas_key),
      .road_collision (road_collision),
      .road_speed     (road_speed),
      .turbo          (turbo),
      .gas_out        (gas_out),
      .recovering     (recovering),
      .charges        (charges),
      .frames_left    (frames_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      n_total++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_left = 0;
      m_ch   = 0;
      m_prev = 1'b0;
   endtask

   // One clock of the spec's rules, evaluated with the inputs present at the edge.
   task automatic model_clock();
      bit edge_seen;
      bit act;
      int ch;
      edge_seen = startOfFrame && turbo_key && !m_prev;
      act = !road_collision && (m_mode == M_IDLE) && edge_seen && (m_ch > 0) && (road_speed >= 3);
      ch = m_ch + (turbo_pickup ? 1 : 0) - (act ? 1 : 0);
      m_ch = (ch > 3) ? 3 : ch;
      if (road_collision) begin
         m_mode = M_REC;
         m_left = 30;
      end else if (act) begin
         m_mode = M_TURBO;
         m_left = 90;
      end else if (startOfFrame && m_mode != M_IDLE) begin
         if (m_left == 1) begin
            if (m_mode == M_TURBO) begin
               m_mode = M_COOL;
               m_left = 60;
            end else begin
               m_mode = M_IDLE;
               m_left = 0;
            end
         end else begin
            m_left = m_left - 1;
         end
      end
      if (startOfFrame) m_prev = turbo_key;
   endtask

   task automatic check_model();
      check("model_turbo", int'(turbo), int'(m_mode == M_TURBO));
      check("model_recovering", int'(recovering), int'(m_mode == M_REC));
      check("model_charges", int'(charges), m_ch);
      check("model_frames_left", int'(frames_left), (m_mode == M_IDLE) ? 0 : m_left);
      check("model_gas_out", int'(gas_out), int'(gas_key && (m_mode != M_REC)));
   endtask

   // One clock: model follows the edge, outputs are checked 1 time unit later, pulses drop.
   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      check_model();
      startOfFrame   = 1'b0;
      turbo_pickup   = 1'b0;
      road_collision = 1'b0;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_turbo", int'(turbo), 0);
      check("rst_recovering", int'(recovering), 0);
      check("rst_charges", int'(charges), 0);
      check("rst_frames_left", int'(frames_left), 0);
      check("rst_gas_out", int'(gas_out), int'(gas_key));
      #3;
      reset = 1'b0;
   endtask

   initial begin
      // Power-on reset
      #12;
      model_reset();
      check("por_charges", int'(charges), 0);
      check("por_turbo", int'(turbo), 0);
      reset = 1'b0;
      @(negedge clk);
      tick();

      // Pickups saturate at three charges
      for (int i = 0; i < 2; i++) begin
         turbo_pickup = 1'b1;
         tick();
      end
      check("pickup_two", int'(charges), 2);
      for (int i = 0; i < 5; i++) begin
         turbo_pickup = 1'b1;
         tick();
      end
      check("pickup_saturate", int'(charges), 3);

      // Full turbo then cooldown with one charge, key held throughout
      async_reset();
      turbo_pickup = 1'b1;
      tick();
      road_speed = 4'd5;
      turbo_key  = 1'b1;
      frame();
      check("act_turbo", int'(turbo), 1);
      check("act_charges", int'(charges), 0);
      check("act_frames", int'(frames_left), 90);
      turbo_pickup = 1'b1;
      tick();
      frames(89);
      check("turbo_last_frame", int'(turbo), 1);
      check("turbo_last_left", int'(frames_left), 1);
      frame();
      check("turbo_off", int'(turbo), 0);
      check("cool_load", int'(frames_left), 60);
      frames(60);
      check("cool_done_frames", int'(frames_left), 0);
      frame();
      check("held_no_retrigger", int'(turbo), 0);
      check("held_charges", int'(charges), 1);

      // Speed gate consumes the edge; no activation until re-press
      road_speed = 4'd2;
      turbo_pickup = 1'b1;
      tick();
      turbo_key = 1'b0;
      frame();
      turbo_key = 1'b1;
      frame();
      check("slow_no_turbo", int'(turbo), 0);
      check("slow_charges", int'(charges), 2);
      road_speed = 4'd3;
      frame();
      check("edge_not_queued", int'(turbo), 0);
      turbo_key = 1'b0;
      frame();
      turbo_key = 1'b1;
      frame();
      check("repress_turbo", int'(turbo), 1);
      check("repress_charges", int'(charges), 1);

      // Collision aborts turbo and masks gas
      frames(50);
      check("turbo_at_40", int'(frames_left), 40);
      gas_key = 1'b1;
      road_collision = 1'b1;
      tick();
      check("coll_turbo", int'(turbo), 0);
      check("coll_recovering", int'(recovering), 1);
      check("coll_frames", int'(frames_left), 30);
      check("coll_gas_masked", int'(gas_out), 0);
      frames(30);
      check("rec_done", int'(recovering), 0);
      check("rec_gas", int'(gas_out), 1);
      check("no_refund", int'(charges), 1);

      // Collision beats a same-cycle activation; second collision reloads the counter
      turbo_key = 1'b0;
      frame();
      turbo_key = 1'b1;
      startOfFrame = 1'b1;
      road_collision = 1'b1;
      tick();
      tick();
      check("coll_act_rec", int'(recovering), 1);
      check("coll_act_charges", int'(charges), 1);
      frames(25);
      check("rec_at_5", int'(frames_left), 5);
      road_collision = 1'b1;
      tick();
      check("rec_reload", int'(frames_left), 30);
      frames(30);
      check("rec_exit_idle", int'(frames_left), 0);

      // Reset in the middle of cooldown
      turbo_pickup = 1'b1;
      tick();
      turbo_pickup = 1'b1;
      tick();
      turbo_key = 1'b0;
      frame();
      turbo_key = 1'b1;
      frame();
      frames(100);
      check("cool_mid_charges", int'(charges), 2);
      check("cool_mid_frames", int'(frames_left), 50);
      async_reset();

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         startOfFrame   = ($urandom_range(2) == 0);
         turbo_pickup   = ($urandom_range(9) == 0);
         road_collision = ($urandom_range(299) == 0);
         if ($urandom_range(5) == 0) turbo_key = ~turbo_key;
         if ($urandom_range(7) == 0) gas_key = ~gas_key;
         if ($urandom_range(15) == 0) road_speed = 4'($urandom_range(15));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
